// File: rtl/draw_rect.sv
// Two-stage rectangle overlay: stage 1 decides hits and addresses the image ROM,
// stage 2 composites the ROM word over the background with the delayed timing.
module draw_rect #(
  parameter int          RECT_WIDTH      = 64,
  parameter int          RECT_HEIGHT     = 64,
  parameter logic [11:0] TRANSPARENT_KEY = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] rgb_pixel,
  output logic [11:0] pixel_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_rect;
  } stage_t;

  logic [11:0] x_l_q, x_l_d, y_l_q, y_l_d;
  logic        vblnk_prev_q;
  logic [11:0] pixel_addr_q, pixel_addr_d;
  stage_t      s1_q, s1_d, s2_q;

  logic [12:0] h13, v13, x13, y13;
  logic        in_rect;
  logic [5:0]  col, row;

  // 13-bit compare so a corner near 4095 extends past the screen instead of wrapping
  always_comb begin
    h13     = {2'b00, hcount_in};
    v13     = {2'b00, vcount_in};
    x13     = {1'b0, x_l_q};
    y13     = {1'b0, y_l_q};
    in_rect = (h13 >= x13) && (h13 < x13 + 13'(RECT_WIDTH)) &&
              (v13 >= y13) && (v13 < y13 + 13'(RECT_HEIGHT));
    col     = hcount_in[5:0] - x_l_q[5:0];
    row     = vcount_in[5:0] - y_l_q[5:0];
    pixel_addr_d = in_rect ? {row, col} : '0;

    s1_d.hcount  = hcount_in;
    s1_d.vcount  = vcount_in;
    s1_d.hsync   = hsync_in;
    s1_d.hblnk   = hblnk_in;
    s1_d.vsync   = vsync_in;
    s1_d.vblnk   = vblnk_in;
    s1_d.rgb     = rgb_in;
    s1_d.in_rect = in_rect;

    x_l_d = x_l_q;
    y_l_d = y_l_q;
    if (vblnk_in && !vblnk_prev_q) begin
      x_l_d = xpos;
      y_l_d = ypos;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_l_q        <= '0;
      y_l_q        <= '0;
      vblnk_prev_q <= 1'b0;
      pixel_addr_q <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
    end else begin
      x_l_q        <= x_l_d;
      y_l_q        <= y_l_d;
      vblnk_prev_q <= vblnk_in;
      pixel_addr_q <= pixel_addr_d;
      s1_q         <= s1_d;
      s2_q         <= s1_q;
    end
  end

  // ROM word arrives during the second stage, so the final mux is combinational
  always_comb begin
    rgb_out = s2_q.rgb;
    if (s2_q.hblnk || s2_q.vblnk)
      rgb_out = '0;
    else if (s2_q.in_rect && (rgb_pixel != TRANSPARENT_KEY))
      rgb_out = rgb_pixel;
  end

  assign pixel_addr = pixel_addr_q;
  assign hcount_out = s2_q.hcount;
  assign vcount_out = s2_q.vcount;
  assign hsync_out  = s2_q.hsync;
  assign hblnk_out  = s2_q.hblnk;
  assign vsync_out  = s2_q.vsync;
  assign vblnk_out  = s2_q.vblnk;

endmodule

// File: tb/tb_draw_rect.sv
// Directed scans plus randomized traffic checked against a frame-level model of the overlay.
module tb_draw_rect;
  localparam logic [11:0] KEY = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, rgb_pixel;
  logic [11:0] pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_rect #(
    .RECT_WIDTH(64),
    .RECT_HEIGHT(64),
    .TRANSPARENT_KEY(KEY)
  ) dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Synchronous image ROM: word for the address presented in the previous cycle
  logic [11:0] rom [4096];
  always @(posedge clk) rgb_pixel <= rom[pixel_addr];

  typedef struct packed {
    logic [11:0] addr;
    logic        inr;
    logic [11:0] rgb;
    logic [10:0] h, v;
    logic        hs, hb, vs, vb;
  } rec_t;

  // Model: pixels enter a 2-deep queue of per-pixel records; a reset empties it
  rec_t rec_q[$];
  int   mx, my;
  bit   mprev;
  rec_t cur, outr;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int h, v;
    logic [11:0] word, exp_rgb;
    @(posedge clk);
    cur = '0;
    if (!rst) begin
      mx = 0; my = 0; mprev = 0;
      rec_q = '{rec_t'('0), rec_t'('0)};
    end else begin
      h = int'(hcount_in);
      v = int'(vcount_in);
      cur.inr  = (h >= mx) && (h < mx + 64) && (v >= my) && (v < my + 64);
      cur.addr = cur.inr ? 12'((((v - my) % 64) * 64) + ((h - mx) % 64)) : 12'h000;
      cur.rgb  = rgb_in;
      cur.h = hcount_in; cur.v = vcount_in;
      cur.hs = hsync_in; cur.hb = hblnk_in; cur.vs = vsync_in; cur.vb = vblnk_in;
      if (vblnk_in && !mprev) begin
        mx = int'(xpos);
        my = int'(ypos);
      end
      mprev = vblnk_in;
      rec_q.push_back(cur);
    end
    outr = rec_q[rec_q.size() - 2];
    cur  = rec_q[rec_q.size() - 1];
    while (rec_q.size() > 2) void'(rec_q.pop_front());
    word = rom[outr.addr];
    if (outr.hb || outr.vb)             exp_rgb = 12'h000;
    else if (outr.inr && word != KEY)   exp_rgb = word;
    else                                exp_rgb = outr.rgb;
    @(negedge clk);
    chk("pixel_addr", 32'(pixel_addr), 32'(cur.addr));
    chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
    chk("timing", 32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}),
        32'({outr.h, outr.v, outr.hs, outr.hb, outr.vs, outr.vb}));
  endtask

  task automatic drive(input int h, input int v, input bit blanks);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = 12'($urandom);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    hblnk_in  = blanks && ($urandom_range(0, 15) == 0);
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) begin
        drive(h, v, 1'b1);
        tick();
      end
  endtask

  // vblnk pulse whose rising cycle hits a pixel inside the old rectangle
  task automatic vpulse(input int h, input int v);
    vblnk_in = 1'b1;
    drive(h, v, 1'b0);
    tick();
    tick();
    vblnk_in = 1'b0;
    drive(0, 0, 1'b0);
    tick();
  endtask

  initial begin
    rec_q = '{rec_t'('0), rec_t'('0)};
    mx = 0; my = 0; mprev = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 12'hABC;
    rst = 1'b0; xpos = 12'd100; ypos = 12'd50; vblnk_in = 1'b1;
    drive(120, 60, 1'b0);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_rgb", 32'(rgb_out), 32'h0);
      chk("reset_addr", 32'(pixel_addr), 32'h0);
    end

    // vblnk already high on the first active cycle latches (100,50)
    rst = 1'b1;
    drive(0, 0, 1'b0);
    tick();
    vblnk_in = 1'b0;
    tick();

    scan(97, 167, 48, 52);
    scan(97, 167, 111, 115);

    drive(100, 50, 1'b0); tick();
    chk("corner_tl", 32'(pixel_addr), 32'h000);
    drive(163, 113, 1'b0); tick();
    chk("corner_br", 32'(pixel_addr), 32'hFFF);
    drive(99, 50, 1'b0); tick();
    chk("left_out", 32'(pixel_addr), 32'h000);
    drive(164, 113, 1'b0); tick();
    chk("right_out", 32'(pixel_addr), 32'h000);
    drive(0, 0, 1'b0); tick();
    chk("right_out_rgb", 32'(rgb_out), 32'(outr.rgb));

    for (int i = 0; i < 4096; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);

    // position change mid-frame: old rectangle must persist until next vblnk edge
    xpos = 12'd300;
    scan(95, 170, 60, 61);
    scan(295, 370, 60, 60);
    vpulse(110, 60);
    scan(95, 170, 70, 70);
    scan(295, 370, 49, 52);

    // reset in the middle of a scanline
    drive(320, 60, 1'b0);
    tick();
    rst = 1'b0;
    drive(330, 60, 1'b0);
    tick();
    rst = 1'b1;
    vblnk_in = 1'b1;
    drive(340, 60, 1'b0);
    tick();
    vblnk_in = 1'b0;
    scan(295, 370, 60, 60);

    // corner near the 12-bit limit must not wrap onto the left edge
    xpos = 12'd4090; ypos = 12'd10;
    vpulse(320, 60);
    scan(0, 80, 10, 11);
    scan(1980, 2047, 20, 20);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        xpos = 12'($urandom_range(0, 200));
        ypos = 12'($urandom_range(0, 150));
      end
      vblnk_in = ($urandom_range(0, 39) == 0);
      rst      = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 300), $urandom_range(0, 230), 1'b1);
      tick();
    end
    rst = 1'b1;
    vblnk_in = 1'b0;
    drive(0, 0, 1'b0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
